// File: rtl/nv_ram_rws_param.sv
// nv_ram_rws_param: parametrised 1R1W flop RAM with a held, registered read
// output (latency 1 or 2), selectable collision semantics, lane-masked
// writes and a self-clearing init sweep that runs after reset or on request.
module nv_ram_rws_param #(
  parameter int WIDTH     = 27,
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter int RD_LAT    = 1,
  parameter int WR_FIRST  = 0,
  parameter int MASK_GRAN = 9,
  localparam int MW       = (WIDTH + MASK_GRAN - 1) / MASK_GRAN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [MW-1:0]    wmask,
  input  logic [WIDTH-1:0] di,
  input  logic             clr_req,
  output logic             init_busy,
  input  logic [31:0]      pwrbus_ram_pd
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             ready;
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] s1_data;
  logic             s1_vld;

  // The power-down bus is carried for interface compatibility only.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  assign ready     = (state == ST_READY);
  assign init_busy = (state == ST_INIT);
  assign wr_ok     = ready && we && ({1'b0, wa} < DEPTH_C);
  assign rd_ok     = ready && re;

  // State and sweep counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: sweep every entry once, then serve until a clear request.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        if (cnt == LAST_C) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Expand the per-lane mask to a per-bit mask and merge the write data
  // with the current contents of the target entry.
  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < WIDTH; b++) begin
      bit_mask[b] = wmask[b / MASK_GRAN];
    end
    wr_data = (di & bit_mask) | (mem[wa] & ~bit_mask);
  end

  // Read-side data selection, including out-of-range zeros and collisions.
  always_comb begin
    rd_data = '0;
    if ({1'b0, ra} < DEPTH_C) begin
      rd_data = mem[ra];
    end
    if ((WR_FIRST != 0) && wr_ok && (wa == ra)) begin
      rd_data = wr_data;
    end
  end

  // Array storage: zeros during the sweep, masked merges in normal operation.
  // NOTE: the array has no reset; the init sweep is what clears it.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wr_data;
    end
  end

  // First read stage: capture data on a read, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= rd_ok;
      if (rd_ok) begin
        s1_data <= rd_data;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s2_data;
      logic             s2_vld;

      // Optional second output stage, also holding between results.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data <= '0;
          s2_vld  <= 1'b0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_data <= s1_data;
          end
        end
      end

      assign dout     = s2_data;
      assign dout_vld = s2_vld;
    end else begin : g_lat1
      assign dout     = s1_data;
      assign dout_vld = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Directed bench for nv_ram_rws_param. Two instances share all inputs:
// u_a uses defaults (DEPTH 256, latency 1, read-old collisions) and u_b uses
// DEPTH 200, latency 2, read-new collisions.
module tb_nv_ram_rws_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ra, wa;
  logic        re, we, clr_req;
  logic [2:0]  wmask;
  logic [26:0] di;
  logic [31:0] pwrbus_ram_pd;

  logic [26:0] dout_a, dout_b;
  logic        vld_a, vld_b, busy_a, busy_b;

  int tests = 0;
  int fails = 0;
  int done_a, done_b;

  always #5 clk = ~clk;

  nv_ram_rws_param u_a (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .clr_req(clr_req),
    .init_busy(busy_a), .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  nv_ram_rws_param #(.DEPTH(200), .RD_LAT(2), .WR_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .clr_req(clr_req),
    .init_busy(busy_b), .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count negedges after rst release until each instance leaves the sweep.
  task automatic sweep_len(input int drop_at);
    done_a = 0;
    done_b = 0;
    for (int c = 1; c <= 400; c++) begin
      if (c == drop_at) begin
        re = 1'b0;
        we = 1'b0;
      end
      @(negedge clk);
      if (!busy_a && done_a == 0) done_a = c;
      if (!busy_b && done_b == 0) done_b = c;
    end
    check("sweep_len_a", done_a, 256);
    check("sweep_len_b", done_b, 200);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [26:0] data, input logic [2:0] mask);
    we = 1'b1; wa = addr; di = data; wmask = mask;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr,
                         input logic [26:0] exp_a, input logic [26:0] exp_b);
    re = 1'b1; ra = addr;
    @(negedge clk);
    re = 1'b0;
    check({tag, "_vld_a"}, vld_a, 1);
    check({tag, "_a"}, dout_a, exp_a);
    check({tag, "_early_vld_b"}, vld_b, 0);
    @(negedge clk);
    check({tag, "_vld_b"}, vld_b, 1);
    check({tag, "_b"}, dout_b, exp_b);
    check({tag, "_late_vld_a"}, vld_a, 0);
  endtask

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; clr_req = 1'b0;
    ra = '0; wa = '0; wmask = '0; di = '0; pwrbus_ram_pd = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy_a", busy_a, 1);
    check("rst_busy_b", busy_b, 1);
    check("rst_vld", {vld_a, vld_b}, 0);
    check("rst_dout_a", dout_a, 0);
    check("rst_dout_b", dout_b, 0);

    // Initial sweep length, then every address reads back zero.
    rst = 1'b0;
    sweep_len(0);
    for (int i = 0; i < 256; i++) begin
      do_read("zero", 8'(i), 27'h0, 27'h0);
    end

    // Full write then read.
    do_write(8'd5, 27'h5A5A5A5, 3'b111);
    do_read("full_wr", 8'd5, 27'h5A5A5A5, 27'h5A5A5A5);

    // Middle lane replaced: bits [17:9] become ones.
    do_write(8'd5, 27'h7FFFFFF, 3'b010);
    do_read("mask_mid", 8'd5, 27'h5A7FFA5, 27'h5A7FFA5);

    // Top lane cleared: bits [26:18] become zeros.
    do_write(8'd5, 27'h0, 3'b100);
    do_read("mask_top", 8'd5, 27'h003FFA5, 27'h003FFA5);

    // Same-cycle collision at address 9 (old contents 0).
    we = 1'b1; wa = 8'd9; di = 27'h123; wmask = 3'b111;
    re = 1'b1; ra = 8'd9;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("coll_vld_a", vld_a, 1);
    check("coll_old_a", dout_a, 27'h0);
    @(negedge clk);
    check("coll_vld_b", vld_b, 1);
    check("coll_new_b", dout_b, 27'h123);
    do_read("coll_after", 8'd9, 27'h123, 27'h123);

    // Back-to-back reads, one result per cycle, then hold.
    re = 1'b1; ra = 8'd5;
    @(negedge clk);
    ra = 8'd9;
    check("b2b_a0", dout_a, 27'h003FFA5);
    check("b2b_vld_a0", vld_a, 1);
    @(negedge clk);
    re = 1'b0;
    check("b2b_a1", dout_a, 27'h123);
    check("b2b_vld_a1", vld_a, 1);
    check("b2b_b0", dout_b, 27'h003FFA5);
    check("b2b_vld_b0", vld_b, 1);
    @(negedge clk);
    check("b2b_b1", dout_b, 27'h123);
    check("b2b_vld_b1", vld_b, 1);
    check("b2b_hold_vld_a", vld_a, 0);
    check("b2b_hold_a", dout_a, 27'h123);

    // A later write to the read address must not disturb the held output.
    do_write(8'd9, 27'h55, 3'b111);
    @(negedge clk);
    check("hold_a", dout_a, 27'h123);
    check("hold_b", dout_b, 27'h123);
    check("hold_vld", {vld_a, vld_b}, 0);

    // Address 210: in range for u_a, out of range (dropped, reads 0) for u_b.
    do_write(8'd210, 27'h1ABCDEF, 3'b111);
    do_read("oor", 8'd210, 27'h1ABCDEF, 27'h0);

    // Read issued together with clr_req completes through the pipeline.
    re = 1'b1; ra = 8'd5; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    check("clr_rd_vld_a", vld_a, 1);
    check("clr_rd_a", dout_a, 27'h003FFA5);
    check("clr_busy", {busy_a, busy_b}, 2'b11);
    @(negedge clk);
    check("clr_rd_vld_b", vld_b, 1);
    check("clr_rd_b", dout_b, 27'h003FFA5);

    // During the clear sweep reads/writes are ignored and dout holds.
    we = 1'b1; wa = 8'd3; di = 27'h7FFFFFF; wmask = 3'b111;
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      check("sweep_no_vld", {vld_a, vld_b}, 0);
      check("sweep_hold_a", dout_a, 27'h003FFA5);
      check("sweep_hold_b", dout_b, 27'h003FFA5);
    end

    // Reset mid-sweep: outputs clear and the sweep restarts from 0.
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {busy_a, busy_b}, 2'b11);
    check("mid_rst_dout_a", dout_a, 0);
    check("mid_rst_dout_b", dout_b, 0);
    rst = 1'b0;
    sweep_len(150);
    check("post_vld", {vld_a, vld_b}, 0);

    // Writes to address 3 during the sweep were ignored; all data is cleared.
    do_read("ign_wr", 8'd3, 27'h0, 27'h0);
    do_read("cleared5", 8'd5, 27'h0, 27'h0);
    do_read("cleared9", 8'd9, 27'h0, 27'h0);
    do_read("cleared210", 8'd210, 27'h0, 27'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
